// File: rtl/couche_substitution_inverse_seq.sv
// Iterative inverse of the ASCON substitution layer: applies the 5-bit inverse S-box
// to COLS_PER_CYCLE columns of the 320-bit state per clock, with a start/done handshake.
module couche_substitution_inverse_seq #(
    parameter int unsigned COLS_PER_CYCLE = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    // State words are packed as {S_0, S_1, S_2, S_3, S_4}: S_r[j] lives at bit 64*(4-r)+j.
    localparam int unsigned NB_STEPS = 64 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1  || COLS_PER_CYCLE == 2  || COLS_PER_CYCLE == 4 ||
          COLS_PER_CYCLE == 8  || COLS_PER_CYCLE == 16 || COLS_PER_CYCLE == 32 ||
          COLS_PER_CYCLE == 64)) begin : g_illegal_cols
        $error("COLS_PER_CYCLE must be a power of two between 1 and 64");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [319:0]     work_q, work_d;
    logic [319:0]     out_q, out_d;
    logic [319:0]     work_upd;
    logic [5:0]       col;
    logic [4:0]       col_in;
    logic [4:0]       col_out;

    function automatic logic [4:0] inv_sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'd0:  y = 5'd20;  5'd1:  y = 5'd26;  5'd2:  y = 5'd7;   5'd3:  y = 5'd13;
            5'd4:  y = 5'd0;   5'd5:  y = 5'd9;   5'd6:  y = 5'd14;  5'd7:  y = 5'd18;
            5'd8:  y = 5'd10;  5'd9:  y = 5'd6;   5'd10: y = 5'd29;  5'd11: y = 5'd1;
            5'd12: y = 5'd25;  5'd13: y = 5'd21;  5'd14: y = 5'd19;  5'd15: y = 5'd30;
            5'd16: y = 5'd24;  5'd17: y = 5'd22;  5'd18: y = 5'd11;  5'd19: y = 5'd17;
            5'd20: y = 5'd3;   5'd21: y = 5'd5;   5'd22: y = 5'd28;  5'd23: y = 5'd31;
            5'd24: y = 5'd23;  5'd25: y = 5'd27;  5'd26: y = 5'd4;   5'd27: y = 5'd8;
            5'd28: y = 5'd15;  5'd29: y = 5'd12;  5'd30: y = 5'd16;  default: y = 5'd2;
        endcase
        return y;
    endfunction

    always_comb begin
        work_upd = work_q;
        col      = '0;
        col_in   = '0;
        col_out  = '0;
        // The column index is the concatenation of the five bits, S_0 as MSB.
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            col     = 6'(cnt_q * COLS_PER_CYCLE) + 6'(i);
            col_in  = {work_q[{3'd4, col}], work_q[{3'd3, col}], work_q[{3'd2, col}],
                       work_q[{3'd1, col}], work_q[{3'd0, col}]};
            col_out = inv_sbox(col_in);
            work_upd[{3'd4, col}] = col_out[4];
            work_upd[{3'd3, col}] = col_out[3];
            work_upd[{3'd2, col}] = col_out[2];
            work_upd[{3'd1, col}] = col_out[1];
            work_upd[{3'd0, col}] = col_out[0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    work_d  = state_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_upd;
                if (cnt_q == LAST_CNT) begin
                    out_d   = work_upd;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign state_o = out_q;

endmodule

// File: tb/tb_couche_substitution_inverse_seq.sv
// Self-checking bench for couche_substitution_inverse_seq: scoreboard of expected results,
// forward ASCON S-box model for round trips, handshake/reset corner cases and a C sweep.
module tb_couche_substitution_inverse_seq;

    localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [319:0] S_RT = {64'h00001000808c0001, 64'h6cb10ad9ca912f80,
                                     64'h691aed630e8190ef, 64'h0c4c36a20853217c,
                                     64'h46487b3e06d9d7a8};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start_sw;
    logic [319:0] state_in;
    logic         ready8, done8, ready1, done1, ready64, done64;
    logic [319:0] out8, out1, out64;

    logic [319:0] exp_q[$];
    logic [319:0] exp_next;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           n_acc    = 0;

    logic [4:0] fwd_tab [32] = '{5'd4, 5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9, 5'd2,
                                 5'd27, 5'd5, 5'd8, 5'd18, 5'd29, 5'd3, 5'd6, 5'd28,
                                 5'd30, 5'd19, 5'd7, 5'd14, 5'd0, 5'd13, 5'd17, 5'd24,
                                 5'd16, 5'd12, 5'd1, 5'd25, 5'd22, 5'd10, 5'd15, 5'd23};
    logic [4:0] inv_tab [32];

    couche_substitution_inverse_seq #(.COLS_PER_CYCLE(8)) dut8 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .state_i(state_in),
        .ready_o(ready8), .done_o(done8), .state_o(out8));

    couche_substitution_inverse_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start_sw), .state_i(state_in),
        .ready_o(ready1), .done_o(done1), .state_o(out1));

    couche_substitution_inverse_seq #(.COLS_PER_CYCLE(64)) dut64 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start_sw), .state_i(state_in),
        .ready_o(ready64), .done_o(done64), .state_o(out64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got hang, required finish)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] ps_apply(input logic [319:0] s, input bit inverse);
        logic [319:0] r;
        logic [4:0]   x, y;
        r = s;
        for (int j = 0; j < 64; j++) begin
            x = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
            y = inverse ? inv_tab[x] : fwd_tab[x];
            r[256+j] = y[4];
            r[192+j] = y[3];
            r[128+j] = y[2];
            r[64+j]  = y[1];
            r[j]     = y[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[k*32 +: 32] = $urandom;
        return s;
    endfunction

    // Acceptance pushes the expected result; every done pulse pops and compares.
    always @(negedge clk) begin
        if (rst_n && start && ready8) begin
            exp_q.push_back(exp_next);
            n_acc++;
        end
        if (done8) begin
            n_done++;
            if (exp_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else check_eq($sformatf("data%0d", n_done), out8, exp_q.pop_front());
        end
    end

    // Called just after a rising edge; returns in the DONE cycle.
    task automatic run_op(input logic [319:0] s, input logic [319:0] e, input string tag);
        int cyc;
        cyc = 0;
        while (!ready8 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        state_in = s;
        exp_next = e;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done8 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq({tag, "_lat"}, cyc, 9);
    endtask

    initial begin
        int           low, d0, a0, cyc, lat1, lat64;
        logic [319:0] va, vb, vc, vh, vd, ve, r;

        for (int x = 0; x < 32; x++) inv_tab[fwd_tab[x]] = 5'(x);
        rst_n    = 1'b0;
        start    = 1'b0;
        start_sw = 1'b0;
        state_in = '0;
        exp_next = '0;
        #1;
        check_eq("rst_ready", ready8, 1);
        check_eq("rst_done", done8, 0);
        check_eq("rst_state", out8, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op('0, {F64, 64'h0, F64, 64'h0, 64'h0}, "zeros");
        run_op({5{F64}}, {64'h0, 64'h0, 64'h0, F64, 64'h0}, "ones");
        run_op({64'h0, 64'h0, F64, 64'h0, 64'h0}, '0, "ps_zero");
        for (int n = 0; n < 3; n++) begin
            r = rand_state();
            run_op(ps_apply(r, 1'b0), r, "rand_rt");
        end
        run_op(ps_apply(S_RT, 1'b0), S_RT, "rt");

        // Extra starts during RUN with other data must be ignored.
        va = rand_state();
        vb = rand_state();
        vc = rand_state();
        @(posedge clk); #1;
        d0 = n_done;
        state_in = va;
        exp_next = ps_apply(va, 1'b1);
        start    = 1'b1;
        @(posedge clk); #1;
        low = 0;
        while (!ready8 && low < 200) begin
            low++;
            if (low == 1) state_in = vb;
            if (low == 2) start = 1'b0;
            if (low == 4) begin
                start    = 1'b1;
                state_in = vc;
                check_eq("hold_prev_result", out8, S_RT);
            end
            if (low == 5) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("ready_low_cycles", low, 9);
        check_eq("hs_single_done", n_done - d0, 1);

        // start held high: one acceptance per IDLE cycle, none in DONE.
        vh = rand_state();
        a0 = n_acc;
        d0 = n_done;
        state_in = vh;
        exp_next = ps_apply(vh, 1'b1);
        start    = 1'b1;
        repeat (20) @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while ((n_done - d0) < 2 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq("held_accepts", n_acc - a0, 2);
        check_eq("held_dones", n_done - d0, 2);

        // Reset in the middle of RUN clears everything with no done pulse.
        while (!ready8) begin
            @(posedge clk); #1;
        end
        vd = rand_state();
        state_in = vd;
        exp_next = ps_apply(vd, 1'b1);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_state", out8, '0);
        check_eq("midrun_rst_done", done8, 0);
        check_eq("midrun_rst_ready", ready8, 1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ve = rand_state();
        run_op(ps_apply(ve, 1'b0), ve, "post_rst");

        // Column-rate sweep on the round-trip vector.
        @(posedge clk); #1;
        state_in = ps_apply(S_RT, 1'b0);
        start_sw = 1'b1;
        @(posedge clk); #1;
        start_sw = 1'b0;
        cyc   = 1;
        lat1  = 0;
        lat64 = 0;
        while ((lat1 == 0 || lat64 == 0) && cyc < 200) begin
            if (done1 && lat1 == 0) begin
                lat1 = cyc;
                check_eq("c1_data", out1, S_RT);
            end
            if (done64 && lat64 == 0) begin
                lat64 = cyc;
                check_eq("c64_data", out64, S_RT);
            end
            @(posedge clk); #1; cyc++;
        end
        check_eq("c1_lat", lat1, 65);
        check_eq("c64_lat", lat64, 2);

        repeat (3) @(posedge clk);
        #1;
        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
